// File: rtl/eic_prio_ctrl_pkg.sv
// Shared constants and types for the external interrupt controller.
//   EXT_INT_SRC_NUM    default number of interrupt sources
//   BUS_*              femto peripheral bus widths and the 4-byte access code
//   EIC_*_OFS          byte offsets of the EIC registers
//   eic_dbg_t          claim/complete state, exported for observation
package eic_prio_ctrl_pkg;

  localparam int EXT_INT_SRC_NUM = 16;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  // 32-byte window; only the first four words are implemented.
  localparam int EIC_SIZE   = 32;
  localparam int EIC_ADDR_W = $clog2(EIC_SIZE);

  localparam logic [EIC_ADDR_W-1:0] EIC_PEND_OFS   = 5'h00;
  localparam logic [EIC_ADDR_W-1:0] EIC_ENABLE_OFS = 5'h04;
  localparam logic [EIC_ADDR_W-1:0] EIC_MODE_OFS   = 5'h08;
  localparam logic [EIC_ADDR_W-1:0] EIC_CLAIM_OFS  = 5'h0C;

  // isr_id is sized for the largest legal SRC_NUM (31 -> 5 bits).
  typedef struct packed {
    logic       busy;
    logic [4:0] isr_id;
  } eic_dbg_t;

endpackage

// File: rtl/eic_prio_enc.sv
// Lowest-index priority encoder.
//   vec    request vector, bit 0 has the highest priority
//   valid  any bit of vec set
//   id     index of the winning bit plus one, 0 when no bit is set
module eic_prio_enc #(
  parameter int N    = 16,
  parameter int ID_W = $clog2(N + 1)
) (
  input  logic [N-1:0]    vec,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  always_comb begin
    valid = |vec;
    id    = '0;
    // Scan from the top down so the lowest set index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) id = ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/eic_prio_ctrl.sv
// External interrupt controller: per-source enable, edge/level mode,
// fixed priority (lowest index wins) and a claim/complete handshake with the core.
//   clk, rstn          clock, asynchronous active-low reset
//   ext_int_trigger    registered interrupt request to the core
//   ext_int_handled    1-cycle completion pulse from the core
//   ext_int_src_vect   raw interrupt lines (synchronous to clk)
//   addr/w_rb/acc/wdata/req   femto bus request
//   rdata/resp         response, one cycle after an accepted request
//   fault              combinational, req with an invalid access
//   dbg_state          busy flag and in-service ID
//
// Bus handshake: req is a single-cycle strobe; a request that does not fault is
// accepted on that edge and answered with resp (plus rdata for reads) exactly one
// cycle later. A faulting request gets no resp and changes no state.
module eic_prio_ctrl
  import eic_prio_ctrl_pkg::*;
#(
  parameter int SRC_NUM = EXT_INT_SRC_NUM,
  parameter int ID_W    = $clog2(SRC_NUM + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic                     ext_int_trigger,
  input  logic                     ext_int_handled,
  input  logic [SRC_NUM-1:0]       ext_int_src_vect,
  input  logic [EIC_ADDR_W-1:0]    addr,
  input  logic                     w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] acc,
  output logic [BUS_WIDTH-1:0]     rdata,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic                     req,
  output logic                     resp,
  output logic                     fault,
  output eic_dbg_t                 dbg_state
);

  logic [SRC_NUM-1:0]   pend_q, pend_d;
  logic [SRC_NUM-1:0]   enable_q, enable_d;
  logic [SRC_NUM-1:0]   mode_q, mode_d;
  logic [SRC_NUM-1:0]   src_prev_q, src_prev_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      isr_id_q, isr_id_d;
  logic                 trigger_q, trigger_d;
  logic                 resp_q, resp_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;

  logic                 sel_pend, sel_enable, sel_mode, sel_claim;
  logic                 acc_ok, rd_acc, wr_acc;
  logic                 claim_fire, complete;
  logic [SRC_NUM-1:0]   src_edge, w1c, claim_clr;
  logic                 win_valid;
  logic [ID_W-1:0]      win_id;
  logic                 unused_wdata;

  // Exact offset match also rejects misaligned and out-of-window addresses.
  assign sel_pend   = (addr == EIC_PEND_OFS);
  assign sel_enable = (addr == EIC_ENABLE_OFS);
  assign sel_mode   = (addr == EIC_MODE_OFS);
  assign sel_claim  = (addr == EIC_CLAIM_OFS);

  assign fault = req & ((acc != BUS_ACC_4B)
                        | ~(sel_pend | sel_enable | sel_mode | sel_claim)
                        | (w_rb & sel_claim));

  assign acc_ok = req & ~fault;
  assign rd_acc = acc_ok & ~w_rb;
  assign wr_acc = acc_ok & w_rb;

  assign unused_wdata = ^wdata[BUS_WIDTH-1:SRC_NUM];

  eic_prio_enc #(
    .N    (SRC_NUM),
    .ID_W (ID_W)
  ) u_prio_enc (
    .vec   (pend_q & enable_q),
    .valid (win_valid),
    .id    (win_id)
  );

  always_comb begin
    src_edge   = ext_int_src_vect & ~src_prev_q;
    src_prev_d = ext_int_src_vect;
    claim_fire = rd_acc & sel_claim & win_valid;
    complete   = ext_int_handled & busy_q;
    w1c        = (wr_acc && sel_pend) ? wdata[SRC_NUM-1:0] : '0;

    claim_clr = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (claim_fire && (win_id == ID_W'(i + 1))) claim_clr[i] = 1'b1;
    end

    // Level bits track the line; edge bits latch, and a new edge wins over
    // any clear landing on the same edge.
    for (int i = 0; i < SRC_NUM; i++) begin
      if (mode_q[i]) pend_d[i] = ext_int_src_vect[i];
      else           pend_d[i] = src_edge[i] | (pend_q[i] & ~w1c[i] & ~claim_clr[i]);
    end

    enable_d = enable_q;
    if (wr_acc && sel_enable) enable_d = wdata[SRC_NUM-1:0];
    mode_d = mode_q;
    if (wr_acc && sel_mode) mode_d = wdata[SRC_NUM-1:0];

    // Complete first, then claim, so a same-cycle pair leaves the new ID in service.
    busy_d   = busy_q;
    isr_id_d = isr_id_q;
    if (complete) begin
      busy_d   = 1'b0;
      isr_id_d = '0;
    end
    if (claim_fire) begin
      busy_d   = 1'b1;
      isr_id_d = win_id;
    end

    // Using next-cycle busy drops the request on the edge that claims it,
    // instead of leaving a stale one-cycle request behind.
    trigger_d = win_valid & ~busy_d;

    resp_d  = acc_ok;
    rdata_d = '0;
    if (rd_acc) begin
      if (sel_pend)   rdata_d[SRC_NUM-1:0] = pend_q;
      if (sel_enable) rdata_d[SRC_NUM-1:0] = enable_q;
      if (sel_mode)   rdata_d[SRC_NUM-1:0] = mode_q;
      if (sel_claim)  rdata_d[ID_W-1:0]    = win_id;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q     <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      src_prev_q <= '0;
      busy_q     <= 1'b0;
      isr_id_q   <= '0;
      trigger_q  <= 1'b0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      src_prev_q <= src_prev_d;
      busy_q     <= busy_d;
      isr_id_q   <= isr_id_d;
      trigger_q  <= trigger_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ext_int_trigger  = trigger_q;
  assign resp             = resp_q;
  assign rdata            = rdata_q;
  assign dbg_state.busy   = busy_q;
  assign dbg_state.isr_id = 5'(isr_id_q);

endmodule

// File: tb/tb_eic_prio_ctrl.sv
module tb_eic_prio_ctrl;
  import eic_prio_ctrl_pkg::*;

  localparam int SRC_NUM = 16;

  logic        clk;
  logic        rstn;
  logic        ext_int_trigger;
  logic        ext_int_handled;
  logic [15:0] ext_int_src_vect;
  logic [4:0]  addr;
  logic        w_rb;
  logic [1:0]  acc;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        req;
  logic        resp;
  logic        fault;
  eic_dbg_t    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  bit          exp_rd_q[$];
  string       name_q[$];

  typedef struct {
    logic        wr;
    logic [4:0]  a;
    logic [1:0]  sz;
    logic [31:0] wd;
    logic        exp_f;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[18];

  eic_prio_ctrl #(.SRC_NUM(SRC_NUM)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .ext_int_trigger  (ext_int_trigger),
    .ext_int_handled  (ext_int_handled),
    .ext_int_src_vect (ext_int_src_vect),
    .addr             (addr),
    .w_rb             (w_rb),
    .acc              (acc),
    .rdata            (rdata),
    .wdata            (wdata),
    .req              (req),
    .resp             (resp),
    .fault            (fault),
    .dbg_state        (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted access produces one resp; reads compare rdata.
  always @(negedge clk) begin
    if (rstn && resp) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", resp, 1'b0);
      end else begin
        logic [31:0] d;
        bit          r;
        string       nm;
        d  = exp_q.pop_front();
        r  = exp_rd_q.pop_front();
        nm = name_q.pop_front();
        if (r) check(nm, rdata, d);
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      check("resp_timeout", exp_q.size(), 0);
      exp_q.delete();
      exp_rd_q.delete();
      name_q.delete();
    end
  endtask

  // Driver tasks: called between edges, request spans one rising edge.
  task automatic bus_acc(input string nm, input logic wr, input logic [4:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input logic exp_f, input logic [31:0] exp_rd,
                         input logic hnd);
    req = 1'b1; w_rb = wr; addr = a; acc = sz; wdata = wd; ext_int_handled = hnd;
    #1;
    check({nm, "_fault"}, fault, exp_f);
    if (!exp_f) begin
      exp_q.push_back(exp_rd);
      exp_rd_q.push_back(!wr);
      name_q.push_back(nm);
    end
    @(negedge clk);
    req = 1'b0; w_rb = 1'b0; wdata = '0; ext_int_handled = 1'b0; acc = BUS_ACC_4B;
    #1;
    if (exp_f) check({nm, "_no_resp"}, resp, 1'b0);
    else       drain();
  endtask

  task automatic bus_read(input string nm, input logic [4:0] a, input logic [31:0] exp_rd);
    bus_acc(nm, 1'b0, a, BUS_ACC_4B, 32'h0, 1'b0, exp_rd, 1'b0);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] wd);
    bus_acc("wr", 1'b1, a, BUS_ACC_4B, wd, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic pulse_handled();
    ext_int_handled = 1'b1;
    @(negedge clk);
    ext_int_handled = 1'b0;
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; ext_int_handled = 1'b0; ext_int_src_vect = '0;
    addr = '0; w_rb = 1'b0; acc = BUS_ACC_4B; wdata = '0; req = 1'b0;

    // Register access and fault table (randomised write data where the value is don't-care).
    vt[0]  = '{1'b1, EIC_ENABLE_OFS, 2'd2, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, EIC_ENABLE_OFS, 2'd2, 32'h0,         1'b0, 32'h0000_FFFF};
    vt[2]  = '{1'b1, EIC_MODE_OFS,   2'd2, 32'h0000_A5A5, 1'b0, 32'h0};
    vt[3]  = '{1'b0, EIC_MODE_OFS,   2'd2, 32'h0,         1'b0, 32'h0000_A5A5};
    vt[4]  = '{1'b1, EIC_MODE_OFS,   2'd2, 32'h0,         1'b0, 32'h0};
    vt[5]  = '{1'b0, EIC_PEND_OFS,   2'd2, 32'h0,         1'b0, 32'h0};
    vt[6]  = '{1'b0, EIC_CLAIM_OFS,  2'd2, 32'h0,         1'b0, 32'h0};
    vt[7]  = '{1'b1, EIC_ENABLE_OFS, 2'd2, 32'h0,         1'b0, 32'h0};
    vt[8]  = '{1'b0, EIC_ENABLE_OFS, 2'd0, 32'h0,         1'b1, 32'h0};
    vt[9]  = '{1'b0, 5'h02,          2'd2, 32'h0,         1'b1, 32'h0};
    vt[10] = '{1'b0, 5'h10,          2'd2, 32'h0,         1'b1, 32'h0};
    vt[11] = '{1'b1, EIC_CLAIM_OFS,  2'd2, 32'h0000_0001, 1'b1, 32'h0};
    vt[12] = '{1'b1, EIC_ENABLE_OFS, 2'd1, 32'h0000_FFFF, 1'b1, 32'h0};
    vt[13] = '{1'b1, 5'h09,          2'd2, 32'h0000_FFFF, 1'b1, 32'h0};
    vt[14] = '{1'b1, 5'h1C,          2'd2, 32'h0000_FFFF, 1'b1, 32'h0};
    vt[15] = '{1'b0, EIC_ENABLE_OFS, 2'd2, 32'h0,         1'b0, 32'h0};
    vt[16] = '{1'b0, EIC_MODE_OFS,   2'd2, 32'h0,         1'b0, 32'h0};
    vt[17] = '{1'b0, EIC_PEND_OFS,   2'd2, 32'h0,         1'b0, 32'h0};
    vt[11].wd = 32'($urandom_range(1, 255));
    vt[12].wd = 32'($urandom_range(1, 16'hFFFF));

    // Reset state
    #3;
    check("rst_trigger", ext_int_trigger, 1'b0);
    check("rst_resp", resp, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dbg", dbg_state, 6'h0);
    check("rst_fault_idle", fault, 1'b0);
    tick(2);
    rstn = 1'b1;
    tick(1);

    for (int i = 0; i < 18; i++) begin
      bus_acc($sformatf("tbl%0d", i), vt[i].wr, vt[i].a, vt[i].sz, vt[i].wd,
              vt[i].exp_f, vt[i].exp_rd, 1'b0);
    end

    // 1: two simultaneous edges, priority and claim/complete
    bus_write(EIC_ENABLE_OFS, 32'h5);
    ext_int_src_vect = 16'h0005;
    tick(2);
    check("t1_trigger", ext_int_trigger, 1'b1);
    bus_read("t1_claim_a", EIC_CLAIM_OFS, 32'd1);
    check("t1_trig_after_claim", ext_int_trigger, 1'b0);
    bus_read("t1_pend", EIC_PEND_OFS, 32'h4);
    check("t1_trig_busy", ext_int_trigger, 1'b0);
    pulse_handled();
    check("t1_trig_again", ext_int_trigger, 1'b1);
    bus_read("t1_claim_b", EIC_CLAIM_OFS, 32'd3);
    pulse_handled();
    tick(1);
    check("t1_trig_idle", ext_int_trigger, 1'b0);
    ext_int_src_vect = '0;
    bus_write(EIC_ENABLE_OFS, 32'h0);

    // 2: level source stays pending across completion
    bus_write(EIC_MODE_OFS, 32'h8);
    bus_write(EIC_ENABLE_OFS, 32'h8);
    ext_int_src_vect = 16'h0008;
    tick(2);
    check("t2_trigger", ext_int_trigger, 1'b1);
    bus_read("t2_claim", EIC_CLAIM_OFS, 32'd4);
    check("t2_trig_busy", ext_int_trigger, 1'b0);
    pulse_handled();
    check("t2_trig_reassert", ext_int_trigger, 1'b1);
    ext_int_src_vect = '0;
    tick(1);
    bus_read("t2_pend_drop", EIC_PEND_OFS, 32'h0);
    check("t2_trig_drop", ext_int_trigger, 1'b0);
    bus_write(EIC_MODE_OFS, 32'h0);
    bus_write(EIC_ENABLE_OFS, 32'h0);

    // 3: pending while disabled, late enable, W1C before claim
    ext_int_src_vect = 16'h0002;
    tick(2);
    bus_read("t3_pend", EIC_PEND_OFS, 32'h2);
    check("t3_trig_disabled", ext_int_trigger, 1'b0);
    bus_write(EIC_ENABLE_OFS, 32'h2);
    tick(1);
    check("t3_trig_enabled", ext_int_trigger, 1'b1);
    bus_write(EIC_PEND_OFS, 32'h2);
    tick(1);
    check("t3_trig_w1c", ext_int_trigger, 1'b0);
    bus_read("t3_claim_none", EIC_CLAIM_OFS, 32'd0);
    check("t3_not_busy", dbg_state, 6'h0);
    ext_int_src_vect = '0;
    bus_write(EIC_ENABLE_OFS, 32'h0);

    // 4a: edge and W1C on the same edge -> set wins
    ext_int_src_vect = 16'h0010;
    bus_write(EIC_PEND_OFS, 32'h10);
    bus_read("t4_pend_set_wins", EIC_PEND_OFS, 32'h10);
    bus_write(EIC_PEND_OFS, 32'h10);
    bus_read("t4_pend_cleared", EIC_PEND_OFS, 32'h0);
    ext_int_src_vect = '0;

    // 4b: complete and claim on the same edge
    bus_write(EIC_ENABLE_OFS, 32'hA1);
    ext_int_src_vect = 16'h00A1;
    tick(2);
    check("t4_trigger", ext_int_trigger, 1'b1);
    bus_read("t4_claim_1", EIC_CLAIM_OFS, 32'd1);
    bus_acc("t4_claim_6", 1'b0, EIC_CLAIM_OFS, BUS_ACC_4B, 32'h0, 1'b0, 32'd6, 1'b1);
    check("t4_dbg_busy6", dbg_state, {1'b1, 5'd6});
    tick(1);
    check("t4_trig_busy", ext_int_trigger, 1'b0);
    pulse_handled();
    check("t4_trig_next", ext_int_trigger, 1'b1);
    bus_read("t4_claim_8", EIC_CLAIM_OFS, 32'd8);
    pulse_handled();
    tick(1);
    check("t4_trig_idle", ext_int_trigger, 1'b0);
    bus_read("t4_claim_none", EIC_CLAIM_OFS, 32'd0);
    ext_int_src_vect = '0;
    bus_write(EIC_ENABLE_OFS, 32'h0);

    // 6: asynchronous reset in the middle of service
    bus_write(EIC_MODE_OFS, 32'h1);
    bus_write(EIC_ENABLE_OFS, 32'hF);
    ext_int_src_vect = 16'h000F;
    tick(2);
    bus_read("t6_claim", EIC_CLAIM_OFS, 32'd1);
    bus_read("t6_pend", EIC_PEND_OFS, 32'hF);
    check("t6_busy", dbg_state, {1'b1, 5'd1});
    req = 1'b1; w_rb = 1'b0; addr = EIC_PEND_OFS; acc = BUS_ACC_4B;
    @(posedge clk);
    #2;
    check("t6_resp_pre", resp, 1'b1);
    check("t6_rdata_pre", rdata, 32'hF);
    rstn = 1'b0;
    #1;
    check("t6_rst_trigger", ext_int_trigger, 1'b0);
    check("t6_rst_resp", resp, 1'b0);
    check("t6_rst_rdata", rdata, 32'h0);
    check("t6_rst_dbg", dbg_state, 6'h0);
    req = 1'b0;
    ext_int_src_vect = '0;
    tick(2);
    rstn = 1'b1;
    #1;
    bus_read("t6_pend_rst", EIC_PEND_OFS, 32'h0);
    bus_read("t6_enable_rst", EIC_ENABLE_OFS, 32'h0);
    bus_read("t6_mode_rst", EIC_MODE_OFS, 32'h0);
    bus_read("t6_claim_rst", EIC_CLAIM_OFS, 32'h0);
    check("t6_trig_rst", ext_int_trigger, 1'b0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
